// File: rtl/pan_mixer.sv
// pan_mixer: constant-power stereo panner and summing bus.
// One frame carries a sample and a pan weight per voice. Voices are issued
// one per cycle through a four-stage pipeline (slew, gain lookup, multiply,
// accumulate) and the saturated stereo sum is registered onto left/right.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for a frame, in_ready high
//   S_RUN   | issuing one channel per cycle into the pipeline
//   S_DRAIN | three cycles for the last channel to reach the accumulator
//   S_DONE  | accumulators final; result registered on exit, may accept
//
// The sine table is computed at elaboration. It holds the same values as the
// sin_lut.txt quarter wave (round(FS*sin(2*pi*i/LUT_SIZE))); only entries
// 0..LUT_SIZE/4 can ever be addressed, so only those are built.

`ifndef SAMPLE_WIDTH
`define SAMPLE_WIDTH 8
`endif
`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif
`ifndef MAX_SAMPLES_PER_PERIOD
`define MAX_SAMPLES_PER_PERIOD 1024
`endif

module pan_mixer #(
  parameter int WIDTH    = `SAMPLE_WIDTH,
  parameter int CHANNELS = 8,
  parameter int LUT_SIZE = `MAX_SAMPLES_PER_PERIOD,
  parameter int SLEW     = 4
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [CHANNELS*(WIDTH+`FIXED_POINT)-1:0]      in,
  input  logic [CHANNELS*32-1:0]                        lr_weight,
  input  logic                                          bypass_slew,
  output logic signed [WIDTH+`FIXED_POINT-1:0]          left,
  output logic signed [WIDTH+`FIXED_POINT-1:0]          right,
  output logic                                          out_valid
);

  localparam int FP  = `FIXED_POINT;
  localparam int W   = WIDTH + FP;
  localparam int QTR = LUT_SIZE / 4;
  localparam int TW  = $clog2(QTR + 1);
  localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW  = W + $clog2(CHANNELS) + 1;

  localparam logic signed [W-1:0]  FS_V    = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  MIN_V   = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [AW-1:0] ACC_MAX = AW'(FS_V);
  localparam logic signed [AW-1:0] ACC_MIN = AW'(MIN_V);
  localparam logic signed [31:0]   W_HI    = 32'sd1 <<< FP;
  localparam logic signed [31:0]   W_LO    = -W_HI;
  localparam logic signed [TW:0]   SLEW_V  = (TW+1)'(SLEW);
  localparam logic [TW-1:0]        CENTRE  = TW'(QTR / 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Quarter-wave sine in Q30 via Taylor series, scaled to full scale and rounded.
  function automatic logic signed [W-1:0] sin_entry(input int idx);
    logic signed [63:0] x, x2, term, sum;
    x    = (64'sd3373259426 * 64'(idx)) / 64'(2 * QTR);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k <= 7; k++) begin
      term = -(((term * x2) >>> 30) / 64'(2 * k * (2 * k + 1)));
      sum  = sum + term;
    end
    return W'((sum * 64'(FS_V) + 64'sd536870912) >>> 30);
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [AW-1:0] a);
    if (a > ACC_MAX)      return FS_V;
    else if (a < ACC_MIN) return MIN_V;
    else                  return W'(a);
  endfunction

  logic signed [W-1:0] lut [0:QTR];

  for (genvar gi = 0; gi <= QTR; gi++) begin : g_lut
    localparam logic signed [W-1:0] ENTRY = sin_entry(gi);
    assign lut[gi] = ENTRY;
  end

  // control
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          drain_q, drain_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic signed [W-1:0] left_q, left_d, right_q, right_d;
  logic                accept, issue, finish;

  // latched frame and per-channel pan angle
  logic signed [W-1:0] frame_s_q [CHANNELS];
  logic signed [W-1:0] frame_s_d [CHANNELS];
  logic signed [31:0]  frame_w_q [CHANNELS];
  logic signed [31:0]  frame_w_d [CHANNELS];
  logic                bypass_q, bypass_d;
  logic [TW-1:0]       theta_q [CHANNELS];
  logic [TW-1:0]       theta_d [CHANNELS];

  // stage-1 combinational terms
  logic signed [31:0]  w_c;
  logic signed [63:0]  prod_w;
  logic [TW-1:0]       target, theta_cur, theta_new;
  logic signed [TW:0]  diff;

  // pipeline registers
  logic                s1_valid_q, s1_valid_d;
  logic [TW-1:0]       s1_theta_q, s1_theta_d;
  logic signed [W-1:0] s1_sample_q, s1_sample_d;
  logic                s2_valid_q, s2_valid_d;
  logic signed [W-1:0] s2_gain_l_q, s2_gain_l_d, s2_gain_r_q, s2_gain_r_d;
  logic signed [W-1:0] s2_sample_q, s2_sample_d;
  logic signed [2*W-1:0] p_l, p_r;
  logic                s3_valid_q, s3_valid_d;
  logic signed [W-1:0] s3_c_l_q, s3_c_l_d, s3_c_r_q, s3_c_r_d;
  logic signed [AW-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;

  assign accept = in_valid && in_ready_q;

  // FSM next state, handshake and output register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    issue   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        issue = 1'b1;
        if (cnt_q == CW'(CHANNELS - 1)) begin
          state_d = S_DRAIN;
          drain_d = 2'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'd2) state_d = S_DONE;
        else                 drain_d = drain_q + 2'd1;
      end
      S_DONE: begin
        finish = 1'b1;
        if (accept) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE) || (state_d == S_DONE);
    out_valid_d = finish;
    left_d      = finish ? sat(acc_l_q) : left_q;
    right_d     = finish ? sat(acc_r_q) : right_q;
  end

  // FSM and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      drain_q     <= 2'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      left_q      <= left_d;
      right_q     <= right_d;
    end
  end

  // Stage 1: clamp weight, derive target angle, slew-limit toward it
  always_comb begin
    w_c = frame_w_q[cnt_q];
    if (w_c > W_HI)      w_c = W_HI;
    else if (w_c < W_LO) w_c = W_LO;
    prod_w    = 64'(w_c) * 64'(LUT_SIZE);
    target    = TW'((64'(LUT_SIZE) + (prod_w >>> FP)) >>> 3);
    theta_cur = theta_q[cnt_q];
    diff      = $signed({1'b0, target}) - $signed({1'b0, theta_cur});
    if (bypass_q)             theta_new = target;
    else if (diff > SLEW_V)   theta_new = theta_cur + TW'(SLEW);
    else if (diff < -SLEW_V)  theta_new = theta_cur - TW'(SLEW);
    else                      theta_new = target;
  end

  // Frame latch on acceptance; theta written back as each channel issues
  always_comb begin
    frame_s_d = frame_s_q;
    frame_w_d = frame_w_q;
    bypass_d  = bypass_q;
    theta_d   = theta_q;
    if (accept) begin
      for (int i = 0; i < CHANNELS; i++) begin
        frame_s_d[i] = in[i*W +: W];
        frame_w_d[i] = lr_weight[i*32 +: 32];
      end
      bypass_d = bypass_slew;
    end
    if (issue) theta_d[cnt_q] = theta_new;
  end

  // Frame storage and per-channel angle registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CHANNELS; i++) begin
        frame_s_q[i] <= '0;
        frame_w_q[i] <= '0;
        theta_q[i]   <= CENTRE;
      end
      bypass_q <= 1'b0;
    end else begin
      frame_s_q <= frame_s_d;
      frame_w_q <= frame_w_d;
      theta_q   <= theta_d;
      bypass_q  <= bypass_d;
    end
  end

  // Stages 1-4 next values: gain lookup, multiply, accumulate
  always_comb begin
    s1_valid_d  = issue;
    s1_theta_d  = theta_new;
    s1_sample_d = frame_s_q[cnt_q];

    s2_valid_d  = s1_valid_q;
    s2_gain_l_d = lut[TW'(QTR) - s1_theta_q];
    s2_gain_r_d = lut[s1_theta_q];
    s2_sample_d = s1_sample_q;

    p_l        = s2_sample_q * s2_gain_l_q;
    p_r        = s2_sample_q * s2_gain_r_q;
    s3_valid_d = s2_valid_q;
    s3_c_l_d   = W'(p_l >>> (W - 1));
    s3_c_r_d   = W'(p_r >>> (W - 1));

    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    if (accept || finish) begin
      acc_l_d = '0;
      acc_r_d = '0;
    end else if (s3_valid_q) begin
      acc_l_d = acc_l_q + AW'(s3_c_l_q);
      acc_r_d = acc_r_q + AW'(s3_c_r_q);
    end
  end

  // Pipeline and accumulator registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_theta_q  <= CENTRE;
      s1_sample_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_gain_l_q <= '0;
      s2_gain_r_q <= '0;
      s2_sample_q <= '0;
      s3_valid_q  <= 1'b0;
      s3_c_l_q    <= '0;
      s3_c_r_q    <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_theta_q  <= s1_theta_d;
      s1_sample_q <= s1_sample_d;
      s2_valid_q  <= s2_valid_d;
      s2_gain_l_q <= s2_gain_l_d;
      s2_gain_r_q <= s2_gain_r_d;
      s2_sample_q <= s2_sample_d;
      s3_valid_q  <= s3_valid_d;
      s3_c_l_q    <= s3_c_l_d;
      s3_c_r_q    <= s3_c_r_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign left      = left_q;
  assign right     = right_q;

endmodule

// File: tb/tb_pan_mixer.sv
// Directed bench for pan_mixer: an 8-voice instance for the main scenarios
// and a 1-voice instance for the single-channel latency case.
// W=16 (8 integer + 8 fractional bits), LUT_SIZE=1024, SLEW=4, FS=32767.

module tb_pan_mixer;

  logic clk = 1'b0;
  logic rstn;

  logic               in_valid;
  logic               in_ready;
  logic [8*16-1:0]    in_bus;
  logic [8*32-1:0]    w_bus;
  logic               bypass;
  logic signed [15:0] left, right;
  logic               out_valid;

  logic               in1_valid;
  logic               in1_ready;
  logic [15:0]        in1_bus;
  logic [31:0]        w1_bus;
  logic               bypass1;
  logic signed [15:0] left1, right1;
  logic               out1_valid;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  pan_mixer #(.WIDTH(8), .CHANNELS(8), .LUT_SIZE(1024), .SLEW(4)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in(in_bus), .lr_weight(w_bus), .bypass_slew(bypass),
    .left(left), .right(right), .out_valid(out_valid)
  );

  pan_mixer #(.WIDTH(8), .CHANNELS(1), .LUT_SIZE(1024), .SLEW(4)) dut1 (
    .clk(clk), .rstn(rstn), .in_valid(in1_valid), .in_ready(in1_ready),
    .in(in1_bus), .lr_weight(w1_bus), .bypass_slew(bypass1),
    .left(left1), .right(right1), .out_valid(out1_valid)
  );

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    chk_cnt++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else             pass_cnt++;
  endtask

  function automatic int lut_ref(input int i);
    return $rtoi($sin(3.14159265358979 * i / 512.0) * 32767.0 + 0.5);
  endfunction

  function automatic int mix(input int x, input int g);
    return (x * g) >>> 15;
  endfunction

  task automatic set_ch(input int ch, input int s, input int w);
    in_bus[ch*16 +: 16] = 16'(s);
    w_bus[ch*32 +: 32]  = w;
  endtask

  task automatic clear_frame();
    in_bus = '0;
    w_bus  = '0;
  endtask

  // Send one frame from idle and check latency, ready pattern, result, pulse width.
  task automatic frame_check(input string tag, input int exp_l, input int exp_r);
    int cyc, rdy;
    cyc = 0;
    while (!in_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    rdy = 0;
    while (!out_valid && cyc < 40) begin
      if (in_ready) rdy++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "/lat"}, out_valid ? cyc : -1, 12);
    chk({tag, "/rdy"}, rdy, 1);
    chk({tag, "/left"}, left, exp_l);
    chk({tag, "/right"}, right, exp_r);
    @(negedge clk);
    chk({tag, "/pulse"}, out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, npulse, th, pulses;
    int pulse_at [4];
    int pl [4];
    int pr [4];

    rstn = 1'b0; in_valid = 1'b0; bypass = 1'b0; clear_frame();
    in1_valid = 1'b0; in1_bus = '0; w1_bus = '0; bypass1 = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst/left", left, 0);
    chk("rst/right", right, 0);
    chk("rst/out_valid", out_valid, 0);
    chk("rst/in_ready", in_ready, 0);
    rstn = 1'b1;
    #1;
    chk("rst/ready_before_edge", in_ready, 0);
    @(negedge clk);
    chk("rst/ready_after_edge", in_ready, 1);

    // single-voice instance: RUN is one cycle, result after 5 edges
    in1_bus = 16'd10000; w1_bus = 32'd0; bypass1 = 1'b1; in1_valid = 1'b1;
    @(negedge clk);
    in1_valid = 1'b0;
    cyc = 0;
    while (!out1_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("ch1/lat", out1_valid ? cyc : -1, 5);
    chk("ch1/left", left1, 7070);
    chk("ch1/right", right1, 7070);

    // centre, hard pans, clamp, multi-voice mix
    bypass = 1'b1;
    clear_frame(); set_ch(0, 10000, 0);
    frame_check("centre", 7070, 7070);
    clear_frame(); set_ch(0, -10000, 0);
    frame_check("centre_neg", -7071, -7071);
    clear_frame(); for (int i = 0; i < 8; i++) set_ch(i, 0, 256); set_ch(0, 10000, 256);
    frame_check("hard_right", 0, 9999);
    clear_frame(); for (int i = 0; i < 8; i++) set_ch(i, 0, -256); set_ch(0, 10000, -256);
    frame_check("hard_left", 9999, 0);
    clear_frame(); for (int i = 0; i < 8; i++) set_ch(i, 0, 768); set_ch(0, 10000, 768);
    frame_check("clamp_right", 0, 9999);
    clear_frame(); set_ch(0, 1000, 256); set_ch(1, 2000, -256); set_ch(2, 4000, 0);
    frame_check("mix3", 4827, 3827);

    // saturation across all eight voices
    clear_frame(); for (int i = 0; i < 8; i++) set_ch(i, 32767, 256);
    frame_check("sat_pos", 0, 32767);
    clear_frame(); for (int i = 0; i < 8; i++) set_ch(i, -32768, 256);
    frame_check("sat_neg", 0, -32768);

    // slew: centre first, then step to full right four LUT steps per frame
    clear_frame(); set_ch(0, 32767, 0);
    frame_check("slew_centre", mix(32767, lut_ref(128)), mix(32767, lut_ref(128)));
    bypass = 1'b0;
    clear_frame(); set_ch(0, 32767, 256);
    for (int n = 1; n <= 34; n++) begin
      th = (128 + 4 * n > 256) ? 256 : 128 + 4 * n;
      frame_check($sformatf("slew%0d", n), mix(32767, lut_ref(256 - th)),
                  mix(32767, lut_ref(th)));
    end
    clear_frame(); set_ch(0, 32767, -256);
    frame_check("slew_down", mix(32767, lut_ref(4)), mix(32767, lut_ref(252)));
    bypass = 1'b1;
    clear_frame(); set_ch(0, 32767, 0);
    frame_check("bypass_centre", mix(32767, lut_ref(128)), mix(32767, lut_ref(128)));
    clear_frame(); set_ch(0, 32767, 256);
    frame_check("bypass_jump", 0, 32766);

    // back-to-back: in_valid held for three frames, inputs changed mid-frame
    clear_frame(); set_ch(0, 10000, 0);
    in_valid = 1'b1;
    @(negedge clk);
    cyc = 0;
    npulse = 0;
    while (cyc < 45) begin
      if (cyc == 2) begin
        clear_frame();
        for (int i = 0; i < 8; i++) set_ch(i, 0, 256);
        set_ch(0, 1000, 256);
      end
      if (cyc == 24) in_valid = 1'b0;
      if (out_valid) begin
        if (npulse < 4) begin
          pulse_at[npulse] = cyc;
          pl[npulse] = left;
          pr[npulse] = right;
        end
        npulse++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("b2b/pulses", npulse, 3);
    pulses = (npulse > 3) ? 3 : npulse;
    for (int k = 0; k < 3; k++) begin
      if (k < pulses) begin
        chk($sformatf("b2b/at%0d", k), pulse_at[k], 12 * (k + 1));
        chk($sformatf("b2b/left%0d", k), pl[k], (k == 0) ? 7070 : 0);
        chk($sformatf("b2b/right%0d", k), pr[k], (k == 0) ? 7070 : 999);
      end else begin
        chk($sformatf("b2b/missing%0d", k), k, -1);
      end
    end

    // reset in the middle of RUN: abort, clear outputs, theta back to centre
    clear_frame(); for (int i = 0; i < 8; i++) set_ch(i, 0, 256); set_ch(0, 10000, 256);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst/left", left, 0);
    chk("midrst/right", right, 0);
    chk("midrst/out_valid", out_valid, 0);
    chk("midrst/in_ready", in_ready, 0);
    @(negedge clk);
    rstn = 1'b1;
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) npulse++;
    end
    chk("midrst/no_pulse", npulse, 0);
    bypass = 1'b0;
    clear_frame(); set_ch(0, 10000, 0);
    frame_check("post_rst", 7070, 7070);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
